// File: rtl/mdu_issue.sv
// mdu_issue: issue sequencer in front of the combinational RV64 M-extension MAC.
//   Accepts one op from EX (in_valid/in_ready) and registers the prepared
//   operands. It drives the MAC one-hot op and sources for LATENCY cycles, then
//   captures and post-processes the result. The result goes out on
//   out_valid/out_ready.
//   Divide-by-zero and signed overflow are resolved locally: the MAC result is
//   undefined for those, so the MAC is never started for them.
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   in_valid/in_ready   request handshake; in_op, in_word, in_src1/2 payload
//   flush               kill; drops any in-flight op, blocks same-cycle accept
//   mac_op/src1/src2    one-hot op {mul,mulh,mulhu,mulhsu,div,divu,rem,remu}, operands
//   mac_result          combinational MAC result
//   out_valid/out_ready response handshake; out_result is the final rd value
module mdu_issue #(
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_op,
  input  logic        in_word,
  input  logic [63:0] in_src1,
  input  logic [63:0] in_src2,
  input  logic        flush,
  output logic [7:0]  mac_op,
  output logic [63:0] mac_src1,
  output logic [63:0] mac_src2,
  input  logic [63:0] mac_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_result
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);
  localparam logic [63:0] MIN64 = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN32 = 64'hFFFF_FFFF_8000_0000;

  state_t      state;
  logic [3:0]  cnt;
  logic        word_q;

  // ---- request decode / operand preparation ----
  logic        is_div, is_rem, div_signed, word_eff;
  logic [63:0] p1, p2;
  logic        div_zero, div_ovf, special;
  logic [63:0] spec_res, post_res;
  logic [7:0]  op_dec;

  always_comb begin
    is_div     = in_op[2];                 // div, divu, rem, remu
    is_rem     = in_op[2] & in_op[1];
    div_signed = in_op[2] & ~in_op[0];     // div, rem
    // W only exists for mul and the divide group; mulh* ignore in_word
    word_eff   = in_word & (in_op == 3'd0 || in_op[2]);
    op_dec     = 8'h80 >> in_op;

    p1 = in_src1;
    p2 = in_src2;
    if (word_eff && is_div) begin
      if (div_signed) begin
        p1 = {{32{in_src1[31]}}, in_src1[31:0]};
        p2 = {{32{in_src2[31]}}, in_src2[31:0]};
      end else begin
        p1 = {32'h0, in_src1[31:0]};
        p2 = {32'h0, in_src2[31:0]};
      end
    end

    // Prepared W operands are already extended, so 64-bit compares give the
    // 32-bit answer.
    div_zero = is_div && (p2 == 64'h0);
    div_ovf  = is_div && div_signed && (p2 == '1) &&
               (p1 == (word_eff ? MIN32 : MIN64));
    special  = div_zero | div_ovf;

    spec_res = 64'h0;
    if (div_zero) begin
      if (is_rem) spec_res = word_eff ? {{32{p1[31]}}, p1[31:0]} : p1;
      else        spec_res = '1;
    end else if (div_ovf) begin
      spec_res = is_rem ? 64'h0 : p1;
    end

    post_res = word_q ? {{32{mac_result[31]}}, mac_result[31:0]} : mac_result;
  end

  // ---- sequencer ----
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'h0;
      word_q     <= 1'b0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      out_result <= 64'h0;
      mac_op     <= 8'h0;
      mac_src1   <= 64'h0;
      mac_src2   <= 64'h0;
    end else if (flush) begin
      state     <= IDLE;
      cnt       <= 4'h0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      mac_op    <= 8'h0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            word_q   <= word_eff;
            mac_src1 <= p1;
            mac_src2 <= p2;
            if (special) begin
              // MAC never started; result known now
              out_result <= spec_res;
              out_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              mac_op <= op_dec;
              cnt    <= CNT_INIT;
              state  <= BUSY;
            end
          end
        end
        BUSY: begin
          if (cnt == 4'h0) begin
            out_result <= post_res;
            out_valid  <= 1'b1;
            mac_op     <= 8'h0;
            state      <= DONE;
          end else begin
            cnt <= cnt - 4'h1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_issue.sv
// tb_mdu_issue: directed bench for mdu_issue (LATENCY=2) with a behavioural
// MAC model driving mac_result from mac_op/mac_src.
module tb_mdu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_word, flush;
  logic [2:0]  in_op;
  logic [63:0] in_src1, in_src2;
  logic [7:0]  mac_op;
  logic [63:0] mac_src1, mac_src2, mac_result;
  logic        out_valid, out_ready;
  logic [63:0] out_result;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mdu_issue #(.LATENCY(2)) dut (
    .clock(clk), .reset(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_word(in_word),
    .in_src1(in_src1), .in_src2(in_src2), .flush(flush),
    .mac_op(mac_op), .mac_src1(mac_src1), .mac_src2(mac_src2),
    .mac_result(mac_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result)
  );

  // Behavioural MAC; undefined cases return a poison value.
  logic [127:0] sa, sb, za, zb;
  always_comb begin
    sa = {{64{mac_src1[63]}}, mac_src1};
    sb = {{64{mac_src2[63]}}, mac_src2};
    za = {64'h0, mac_src1};
    zb = {64'h0, mac_src2};
    mac_result = 64'hDEAD_BEEF_DEAD_BEEF;
    case (mac_op)
      8'h80: mac_result = mac_src1 * mac_src2;
      8'h40: mac_result = 64'((sa * sb) >> 64);
      8'h20: mac_result = 64'((za * zb) >> 64);
      8'h10: mac_result = 64'((sa * zb) >> 64);
      8'h08: if (mac_src2 != 0) mac_result = $signed(mac_src1) / $signed(mac_src2);
      8'h04: if (mac_src2 != 0) mac_result = mac_src1 / mac_src2;
      8'h02: if (mac_src2 != 0) mac_result = $signed(mac_src1) % $signed(mac_src2);
      8'h01: if (mac_src2 != 0) mac_result = mac_src1 % mac_src2;
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // present one op for a single cycle; returns #1 after the accept edge
  task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a, input logic [63:0] b);
    in_op = op; in_word = w; in_src1 = a; in_src2 = b; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // count cycles after accept until out_valid (1 = already valid)
  task automatic wait_valid(input string tag, input int exp_lat);
    int n;
    n = 1;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_ov_drop"}, 64'(out_valid), 64'd0);
    chk({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = 3'd0; in_word = 1'b0;
    in_src1 = 64'h0; in_src2 = 64'h0; flush = 1'b0; out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", out_result, 64'h0);
    chk("rst_mac_op", 64'(mac_op), 64'h0);
    chk("rst_mac_src1", mac_src1, 64'h0);
    chk("rst_mac_src2", mac_src2, 64'h0);
    rst_n = 1'b1;
    step();

    // mulhu: op held two cycles, out_valid at accept+3
    issue(3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2);
    chk("mulhu_op_c1", 64'(mac_op), 64'h20);
    chk("mulhu_rdy_c1", 64'(in_ready), 64'd0);
    chk("mulhu_ov_c1", 64'(out_valid), 64'd0);
    step();
    chk("mulhu_op_c2", 64'(mac_op), 64'h20);
    chk("mulhu_ov_c2", 64'(out_valid), 64'd0);
    step();
    chk("mulhu_ov_c3", 64'(out_valid), 64'd1);
    chk("mulhu_res", out_result, 64'h1);
    chk("mulhu_op_done", 64'(mac_op), 64'h0);
    drain("mulhu");

    // divw: sign-extended operand to MAC, word result
    issue(3'd4, 1'b1, 64'h0000_0000_FFFF_FFF9, 64'd2);
    chk("divw_src1", mac_src1, 64'hFFFF_FFFF_FFFF_FFF9);
    chk("divw_op", 64'(mac_op), 64'h08);
    wait_valid("divw", 3);
    chk("divw_res", out_result, 64'hFFFF_FFFF_FFFF_FFFD);
    drain("divw");

    // mulw: operands unchanged, result sign-extended from bit 31
    issue(3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2);
    chk("mulw_src1", mac_src1, 64'h0000_0000_7FFF_FFFF);
    wait_valid("mulw", 3);
    chk("mulw_res", out_result, 64'hFFFF_FFFF_FFFF_FFFE);
    drain("mulw");

    // div by zero: latency 1, MAC not started
    issue(3'd4, 1'b0, 64'd1234, 64'd0);
    chk("divz_ov", 64'(out_valid), 64'd1);
    chk("divz_op", 64'(mac_op), 64'h0);
    chk("divz_res", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    drain("divz");

    issue(3'd7, 1'b1, 64'h0000_0001_8000_0000, 64'd0);
    chk("remuwz_ov", 64'(out_valid), 64'd1);
    chk("remuwz_res", out_result, 64'hFFFF_FFFF_8000_0000);
    drain("remuwz");

    // signed overflow
    issue(3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("divovf_ov", 64'(out_valid), 64'd1);
    chk("divovf_op", 64'(mac_op), 64'h0);
    chk("divovf_res", out_result, 64'h8000_0000_0000_0000);
    drain("divovf");

    issue(3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("removf_ov", 64'(out_valid), 64'd1);
    chk("removf_res", out_result, 64'h0);
    drain("removf");

    issue(3'd4, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF);
    chk("divwovf_ov", 64'(out_valid), 64'd1);
    chk("divwovf_res", out_result, 64'hFFFF_FFFF_8000_0000);
    drain("divwovf");

    // backpressure in DONE
    issue(3'd0, 1'b0, 64'd3, 64'd5);
    wait_valid("mul", 3);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ov", 64'(out_valid), 64'd1);
      chk("hold_res", out_result, 64'd15);
      chk("hold_rdy", 64'(in_ready), 64'd0);
      step();
    end
    drain("hold");

    // flush on first BUSY cycle
    issue(3'd0, 1'b0, 64'd7, 64'd6);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_op", 64'(mac_op), 64'h0);
    chk("flush_ov", 64'(out_valid), 64'd0);
    chk("flush_rdy", 64'(in_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      chk("flush_no_ov", 64'(out_valid), 64'd0);
      step();
    end
    issue(3'd1, 1'b0, 64'h8000_0000_0000_0000, 64'd2);
    chk("mulh_op", 64'(mac_op), 64'h40);
    wait_valid("mulh", 3);
    chk("mulh_res", out_result, 64'hFFFF_FFFF_FFFF_FFFF);
    drain("mulh");

    // flush with in_valid in IDLE: not accepted
    in_op = 3'd0; in_word = 1'b0; in_src1 = 64'd2; in_src2 = 64'd2;
    in_valid = 1'b1; flush = 1'b1;
    step();
    in_valid = 1'b0; flush = 1'b0;
    chk("flushacc_rdy", 64'(in_ready), 64'd1);
    chk("flushacc_op", 64'(mac_op), 64'h0);
    step();
    chk("flushacc_ov", 64'(out_valid), 64'd0);

    // reset while in DONE
    issue(3'd5, 1'b0, 64'd9, 64'd0);
    chk("rstdone_ov_pre", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rstdone_ov", 64'(out_valid), 64'd0);
    chk("rstdone_res", out_result, 64'h0);
    chk("rstdone_rdy", 64'(in_ready), 64'd1);
    step();
    rst_n = 1'b1;
    step();
    chk("rstdone_ov_after", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_issue.md
Name: mdu_issue

Overview:
- Sequencer that sits directly upstream of the combinational multiply/divide unit (MAC) in the RV64 execute stage.
- Accepts one M-extension operation from EX through a valid/ready handshake and registers the operands.
- Drives the MAC's one-hot op lines and sources, holding them stable for a multicycle settling window, then captures and post-processes the result.
- Returns the result to EX/WB through a second valid/ready handshake. Handles RV64 W-variants and RISC-V divide-by-zero/overflow semantics, because the MAC result is undefined in those cases.

Parameters:
- LATENCY, 2, number of cycles the MAC inputs are held before the result is sampled; legal range 1..15.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  EX presents an operation.
- in_ready  out  1  block can accept an operation.
- in_op  in  3  0 mul, 1 mulh, 2 mulhu, 3 mulhsu, 4 div, 5 divu, 6 rem, 7 remu.
- in_word  in  1  W-variant (mulw/divw/divuw/remw/remuw); ignored for in_op 1..3.
- in_src1  in  64  rs1 value.
- in_src2  in  64  rs2 value.
- flush  in  1  pipeline kill; drops any in-flight operation.
- mac_op  out  8  one-hot to MAC, bit order {mul, mulh, mulhu, mulhsu, div, divu, rem, remu} MSB..LSB.
- mac_src1  out  64  MAC operand 1.
- mac_src2  out  64  MAC operand 2.
- mac_result  in  64  MAC combinational result.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result.
- out_result  out  64  final rd value.

Behaviour:
- Reset values: state IDLE, in_ready 1, out_valid 0, out_result 0, mac_op 0, mac_src1/mac_src2 0, counter 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, mac_op=0.
  - in_valid=1 registers op, word flag and the prepared operands.
  - Next state is DONE if a special case is detected; otherwise BUSY with counter=LATENCY-1.
- Operand preparation for word div/rem:
  - divw/remw: sign-extend src[31:0].
  - divuw/remuw: zero-extend src[31:0].
  - mulw passes both operands unchanged.
- BUSY:
  - mac_op/mac_src driven from registers, constant for the whole state.
  - Counter decrements each cycle.
  - At counter==0, capture the post-processed mac_result into out_result and go to DONE.
  - Accept-to-out_valid latency is exactly LATENCY+1 cycles.
- Post-processing:
  - Word ops: out_result = sign-extend(mac_result[31:0]).
  - Otherwise out_result = mac_result.
- Special cases, detected at accept on the prepared operands and evaluated at 32-bit width for W ops:
  - Divisor zero: div/divu give all ones, then word sign-extension; rem/remu give the dividend, sign-extended for W.
  - Signed overflow: div/divw with dividend = most-negative value and divisor = -1. Quotient = dividend (0x8000000000000000, or 0xFFFFFFFF80000000 for W); rem = 0.
  - Special cases skip BUSY. out_valid asserts on the cycle after accept (latency 1), and mac_op stays 0.
- DONE:
  - out_valid=1; out_result held stable until out_valid && out_ready.
  - Then go to IDLE; in_ready rises the following cycle. No same-cycle accept in DONE.
- flush:
  - In any state, go to IDLE next cycle with out_valid=0 and mac_op=0; the result is discarded.
  - flush together with in_valid in IDLE: the operation is not accepted.
- Reset asserted mid-operation immediately forces the reset values; no result is produced.
- One operation in flight at most; in_ready=0 in BUSY and DONE.

Test Plan:
- LATENCY=2, mulhu src1=0xFFFFFFFFFFFFFFFF, src2=2, mac modelled → mac_op=0x20 held 2 cycles; out_valid at accept+3; out_result=0x1.
- divw src1=0x00000000_FFFFFFF9, src2=2 → mac_src1=0xFFFFFFFFFFFFFFF9; out_result=0xFFFFFFFFFFFFFFFD.
- div src2=0 → out_valid at accept+1, out_result=0xFFFFFFFFFFFFFFFF, mac_op stays 0. remuw src1=0x1_80000000, src2=0 → out_result=0xFFFFFFFF80000000.
- div src1=0x8000000000000000, src2=-1 → out_result=0x8000000000000000; rem with the same operands → 0.
- Hold out_ready=0 for 5 cycles in DONE → out_valid and out_result stable, in_ready=0; raise out_ready → IDLE, in_ready=1 next cycle.
- flush on the first BUSY cycle → no out_valid; next op accepted normally. Asserting reset in DONE → out_valid=0 immediately.
